// File: rtl/baud_cfg_ctrl.sv
// Baud generator configuration sequencer: drain the UART, hold the generator in reset with new selects, confirm lock.
// Define BAUD_CFG_PENDING_EN to add a one-entry buffer for writes arriving while a sequence is in progress.

module baud_cfg_ctrl #(
  parameter int         HOLD_CYCLES    = 4,
  parameter int         LOCK_EDGES     = 2,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [1:0] RESET_SEL      = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_baud_sel,
  input  logic       cfg_en_50mhz,
  input  logic       uart_busy,
  input  logic       baud_in,
  output logic       uart_hold,
  output logic       gen_rst,
  output logic [1:0] baud_sel_o,
  output logic       en_50mhz_o,
  output logic       cfg_busy,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic       cfg_drop
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int EDGE_W = $clog2(LOCK_EDGES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(LOCK_EDGES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        sync_q, sync_d;
  logic              edge_q, edge_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]        shadow_sel_q, shadow_sel_d;
  logic              shadow_en_q, shadow_en_d;
  logic [1:0]        sel_q, sel_d;
  logic              en_q, en_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;

  logic              accept_wr;
  logic              busy_wr;
  logic              lock_hit;
  logic              tmo_hit;
  logic              lock_done;
  logic              chain_next;
  logic              drop_evt;
  logic [1:0]        chain_sel;
  logic              chain_en;

  // Stage 0/1 synchronise baud_in; stage 2 holds the previous synchronised value for edge detection.
  assign sync_d[0] = baud_in;
  for (genvar gi = 1; gi < 3; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end

  assign edge_d = sync_q[1] & ~sync_q[2];

  assign accept_wr = (state_q == ST_IDLE) && cfg_wr;
  assign busy_wr   = (state_q != ST_IDLE) && cfg_wr;
  assign lock_hit  = (state_q == ST_LOCK) && edge_q && (edge_cnt_q == EDGE_LAST);
  assign tmo_hit   = (state_q == ST_LOCK) && (tmo_cnt_q == TMO_LAST);
  assign lock_done = lock_hit || tmo_hit;

`ifdef BAUD_CFG_PENDING_EN
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_sel_q, pend_sel_d;
  logic       pend_en_q, pend_en_d;

  // A write landing in the same cycle LOCK ends supersedes any buffered entry.
  assign chain_next = pend_valid_q || busy_wr;
  assign chain_sel  = busy_wr ? cfg_baud_sel : pend_sel_q;
  assign chain_en   = busy_wr ? cfg_en_50mhz : pend_en_q;
  assign drop_evt   = busy_wr && pend_valid_q;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    pend_en_d    = pend_en_q;
    if (lock_done && chain_next) begin
      pend_valid_d = 1'b0;
    end else if (busy_wr) begin
      pend_valid_d = 1'b1;
      pend_sel_d   = cfg_baud_sel;
      pend_en_d    = cfg_en_50mhz;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_sel_q   <= 2'b00;
      pend_en_q    <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_en_q    <= pend_en_d;
    end
  end
`else
  assign chain_next = 1'b0;
  assign chain_sel  = shadow_sel_q;
  assign chain_en   = shadow_en_q;
  assign drop_evt   = busy_wr;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_APPLY;
      sync_q       <= 3'b000;
      edge_q       <= 1'b0;
      hold_cnt_q   <= HOLD_LOAD;
      edge_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      shadow_sel_q <= RESET_SEL;
      shadow_en_q  <= 1'b0;
      sel_q        <= RESET_SEL;
      en_q         <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      hold_cnt_q   <= hold_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_en_q  <= shadow_en_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_wr) state_d = ST_DRAIN;
      ST_DRAIN: if (!uart_busy) state_d = ST_APPLY;
      ST_APPLY: if (hold_cnt_q == '0) state_d = ST_LOCK;
      ST_LOCK:  if (lock_done) state_d = chain_next ? ST_DRAIN : ST_IDLE;
      default:  state_d = ST_APPLY;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    shadow_sel_d = shadow_sel_q;
    shadow_en_d  = shadow_en_q;
    sel_d        = sel_q;
    en_d         = en_q;
    ready_d      = ready_q;
    err_d        = err_q;
    drop_d       = drop_q;

    if (accept_wr) begin
      shadow_sel_d = cfg_baud_sel;
      shadow_en_d  = cfg_en_50mhz;
      ready_d      = 1'b0;
      err_d        = 1'b0;
      drop_d       = 1'b0;
    end
    if (drop_evt) drop_d = 1'b1;

    unique case (state_q)
      ST_DRAIN: begin
        if (!uart_busy) begin
          sel_d      = shadow_sel_q;
          en_d       = shadow_en_q;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_APPLY: begin
        // Edges seen while the generator is held in reset must not count toward lock.
        if (hold_cnt_q == '0) begin
          edge_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_LOCK: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (edge_q) edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        if (lock_hit && !chain_next) ready_d = 1'b1;
        if (tmo_hit && !lock_hit) err_d = 1'b1;
        if (lock_done && chain_next) begin
          shadow_sel_d = chain_sel;
          shadow_en_d  = chain_en;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    gen_rst   = 1'b1;
    uart_hold = 1'b1;
    cfg_busy  = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        uart_hold = 1'b0;
        cfg_busy  = 1'b0;
      end
      ST_APPLY: gen_rst = 1'b0;
      default: ;
    endcase
  end

  assign baud_sel_o = sel_q;
  assign en_50mhz_o = en_q;
  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;
  assign cfg_drop   = drop_q;

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
Configuration sequencer for the UART baud-rate generator. Accepts baud/clock-mode updates from the CPU register interface and waits for the UART to drain. It then holds the generator in reset, applies the new select lines, releases reset and confirms the new baud output is toggling before reporting ready. Sits between the memory-mapped UART control register and the baud generator/UART core.

Parameters:
HOLD_CYCLES, 4, cycles generator reset is held low while new selects settle (>=1)
LOCK_EDGES, 2, rising edges of baud_in required to declare lock (>=1)
TIMEOUT_CYCLES, 100000, max cycles in LOCK before error (covers 2 periods of 9600 at 100 MHz)
RESET_SEL, 2'b00, baud_sel applied out of reset (00=9600, 01=19200, 10=57600, 11=115200)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
cfg_wr  input  1  one-cycle config write strobe
cfg_baud_sel  input  2  requested baud select
cfg_en_50mhz  input  1  requested 50 MHz mode
uart_busy  input  1  UART TX/RX frame in progress
baud_in  input  1  baud generator output (asynchronous to clk edges)
uart_hold  output  1  request UART not to start a new frame
gen_rst  output  1  active-low reset to baud generator
baud_sel_o  output  2  baud select driven to generator
en_50mhz_o  output  1  50 MHz mode to generator
cfg_busy  output  1  sequence in progress; cfg_wr not accepted
cfg_ready  output  1  generator locked on current config
cfg_err  output  1  sticky: lock timeout occurred
cfg_drop  output  1  sticky: cfg_wr arrived while busy and was discarded

Behaviour:
- One clock, rst synchronous active-low; all state changes on rising clk.
- Reset values: state=APPLY, gen_rst=0, baud_sel_o=RESET_SEL, en_50mhz_o=0, uart_hold=1, cfg_busy=1, cfg_ready=0, cfg_err=0, cfg_drop=0.
- baud_in passes through a 2-flop synchronizer, then a rising-edge detector. Edge pulse appears 3 clk after the baud_in rise.
- States: IDLE, DRAIN, APPLY, LOCK.
- IDLE: cfg_busy=0, uart_hold=0, gen_rst=1.
  - cfg_wr=1: latch cfg_baud_sel/cfg_en_50mhz into a shadow register; clear cfg_ready; go to DRAIN next cycle.
- DRAIN: uart_hold=1, cfg_busy=1.
  - Stay while uart_busy=1. No timeout; UART finishes its current frame.
  - When uart_busy=0: copy shadow to baud_sel_o/en_50mhz_o, drive gen_rst=0, load hold counter; go to APPLY.
- APPLY: gen_rst=0 for exactly HOLD_CYCLES cycles. Selects stable the whole time.
  - Then gen_rst=1, clear edge and timeout counters; go to LOCK.
- LOCK: gen_rst=1, uart_hold=1.
  - Count sync'd rising edges.
  - On edge count reaching LOCK_EDGES: cfg_ready=1, go to IDLE.
  - On timeout counter reaching TIMEOUT_CYCLES-1 first: cfg_err=1, cfg_ready=0, go to IDLE.
  - If lock and timeout occur in the same cycle, lock wins.
- Post-reset: path is APPLY -> LOCK using RESET_SEL; DRAIN is skipped.
- cfg_wr while cfg_busy=1: discarded, cfg_drop set. cfg_wr in IDLE is always accepted.
- cfg_err and cfg_drop are cleared only by a cfg_wr accepted in IDLE, or by rst.
- cfg_ready stays 1 in IDLE until the next accepted cfg_wr.
- Config equal to current: a write is still accepted and the full sequence runs.
- rst low mid-sequence: immediate return to reset values next edge; shadow register discarded.
- Counter widths are $clog2(param+1); no wrap-around is possible within a state.

Optional Feature:
BAUD_CFG_PENDING_EN
- Defined: adds a one-entry pending buffer.
  - A cfg_wr while busy stores its value in the buffer; a later cfg_wr while busy overwrites it. cfg_drop is set only on overwrite.
  - On leaving LOCK with a pending entry: go directly to DRAIN with the pending value; cfg_busy stays 1.
  - cfg_ready pulses for 0 cycles in this case (remains 0).
  - Pending entry cleared by rst.
- Not defined: writes while busy are discarded and set cfg_drop, as above.

Test Plan:
- Reset release, baud_in toggling every 10 cycles -> gen_rst low 4 cycles with baud_sel_o=00; then cfg_ready=1 after 2nd sync'd rising edge, cfg_busy=0.
- In IDLE, cfg_wr sel=11 en=1 with uart_busy=1 for 50 cycles -> uart_hold=1 immediately; baud_sel_o stays 00 until uart_busy falls; then gen_rst=0 exactly 4 cycles, baud_sel_o=11, en_50mhz_o=1.
- baud_in held 0 in LOCK -> cfg_err=1 and state IDLE exactly 100000 cycles after gen_rst release; cfg_ready=0. Next accepted cfg_wr clears cfg_err.
- cfg_wr sel=01 during APPLY -> cfg_drop=1; baud_sel_o unchanged. With BAUD_CFG_PENDING_EN: no cfg_drop, second sequence runs with sel=01 without returning cfg_busy to 0.
- rst asserted mid-LOCK after config 10 -> next cycle all outputs at reset values, baud_sel_o=00, gen_rst=0.
- Lock edge and timeout in the same cycle (TIMEOUT_CYCLES=30, edge timed at cycle 29) -> cfg_ready=1, cfg_err=0.
